// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment capture path: pattern table, blank code, FSM states.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    WAIT_SEL = 2'd0,
    SETTLE   = 2'd1,
    CAPTURE  = 2'd2,
    HOLD     = 2'd3
  } state_t;

  typedef struct packed {
    logic       hit;
    logic       blank;
    logic [3:0] nibble;
  } decode_t;

  // Pattern for a hex nibble; table is segment a = bit 6, inverse numbering mirrors the bits.
  function automatic logic [6:0] seg_pattern(input logic [3:0] nibble, input logic inverse);
    logic [6:0] p;
    logic [6:0] r;
    case (nibble)
      4'h0: p = 7'h7e;
      4'h1: p = 7'h30;
      4'h2: p = 7'h6d;
      4'h3: p = 7'h79;
      4'h4: p = 7'h33;
      4'h5: p = 7'h5b;
      4'h6: p = 7'h5f;
      4'h7: p = 7'h70;
      4'h8: p = 7'h7f;
      4'h9: p = 7'h7b;
      4'ha: p = 7'h77;
      4'hb: p = 7'h1f;
      4'hc: p = 7'h4e;
      4'hd: p = 7'h3d;
      4'he: p = 7'h4f;
      4'hf: p = 7'h47;
      default: p = SEG_BLANK;
    endcase
    for (int b = 0; b < 7; b++) begin
      r[b] = p[6-b];
    end
    return inverse ? r : p;
  endfunction

endpackage

// File: rtl/sevenseg_capture_if.sv
// Pin-side and result signals of sevenseg_capture; decimal point lines exist when
// SEVENSEG_CAPTURE_DP_EN is defined.
interface sevenseg_capture_if #(
  parameter int NUM_DIGITS = 4
);
  logic [6:0]              in_segs;
  logic [NUM_DIGITS-1:0]   in_sel;
  logic [4*NUM_DIGITS-1:0] out_digits;
  logic [NUM_DIGITS-1:0]   out_valid;
  logic                    out_update;
  logic                    out_err;
  logic                    out_frame;
`ifdef SEVENSEG_CAPTURE_DP_EN
  logic                    in_dp;
  logic [NUM_DIGITS-1:0]   out_dps;
`endif

  modport master (
`ifdef SEVENSEG_CAPTURE_DP_EN
    output in_dp,
    input  out_dps,
`endif
    output in_segs, in_sel,
    input  out_digits, out_valid, out_update, out_err, out_frame
  );

  modport slave (
`ifdef SEVENSEG_CAPTURE_DP_EN
    input  in_dp,
    output out_dps,
`endif
    input  in_segs, in_sel,
    output out_digits, out_valid, out_update, out_err, out_frame
  );
endinterface

// File: rtl/sevenseg_decode.sv
// Exact-match decoder from a 7-bit segment pattern to {hit, blank, nibble}.
module sevenseg_decode
  import sevenseg_pkg::*;
#(
  parameter bit INVERSE_NUMBERING = 1'b0
) (
  input  logic [6:0] pattern,
  output decode_t    result
);

  logic [15:0] match_s;

  // Table patterns are distinct, so at most one match bit is set and OR-ing indices is exact.
  always_comb begin
    result.hit    = 1'b0;
    result.blank  = (pattern == SEG_BLANK);
    result.nibble = 4'h0;
    for (int i = 0; i < 16; i++) begin
      match_s[i]    = (pattern == seg_pattern(4'(i), INVERSE_NUMBERING));
      result.nibble = result.nibble | (match_s[i] ? 4'(i) : 4'h0);
    end
    result.hit = |match_s;
  end

endmodule

// File: rtl/sevenseg_capture.sv
// Reconstructs hex digits from a scanned seven-segment bus (synchronise, settle, decode, store).
// Optional decimal point capture is enabled by defining SEVENSEG_CAPTURE_DP_EN.
module sevenseg_capture
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS        = 4,
  parameter bit ZERO_IS_ON        = 1'b0,
  parameter bit SEL_ZERO_IS_ON    = 1'b0,
  parameter bit INVERSE_NUMBERING = 1'b0,
  parameter int STABLE_CYCLES     = 4
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  sevenseg_capture_if.slave  bus
);

`ifdef SEVENSEG_CAPTURE_DP_EN
  localparam int SMP_W = 8;
`else
  localparam int SMP_W = 7;
`endif
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [SMP_W-1:0]      SMP_INV  = {SMP_W{ZERO_IS_ON}};
  localparam logic [NUM_DIGITS-1:0] SEL_INV  = {NUM_DIGITS{SEL_ZERO_IS_ON}};

  logic [SMP_W-1:0]        smp_pin_s;
  logic [SMP_W-1:0]        smp_meta_r;
  logic [SMP_W-1:0]        smp_sync_r;
  logic [SMP_W-1:0]        smp_s;
  logic [NUM_DIGITS-1:0]   sel_meta_r;
  logic [NUM_DIGITS-1:0]   sel_sync_r;
  logic [NUM_DIGITS-1:0]   sel_s;
  logic                    sel_valid_s;

  state_t                  state_r;
  logic [NUM_DIGITS-1:0]   sel_lat_r;
  logic [SMP_W-1:0]        smp_lat_r;
  logic [CNT_W-1:0]        cnt_r;
  logic [IDX_W-1:0]        idx_s;
  logic [NUM_DIGITS-1:0]   mask_r;
  logic [NUM_DIGITS-1:0]   mask_set_s;
  logic [4*NUM_DIGITS-1:0] digits_r;
  logic [NUM_DIGITS-1:0]   valid_r;
  logic                    update_r;
  logic                    err_r;
  logic                    frame_r;
  decode_t                 dec_s;

`ifdef SEVENSEG_CAPTURE_DP_EN
  logic [NUM_DIGITS-1:0]   dps_r;
  assign smp_pin_s   = {bus.in_dp, bus.in_segs};
  assign bus.out_dps = dps_r;
`else
  assign smp_pin_s   = bus.in_segs;
`endif

  // Two-flop synchronisers; reset to the raw level that reads as inactive after polarity fix.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      smp_meta_r <= SMP_INV;
      smp_sync_r <= SMP_INV;
      sel_meta_r <= SEL_INV;
      sel_sync_r <= SEL_INV;
    end else begin
      smp_meta_r <= smp_pin_s;
      smp_sync_r <= smp_meta_r;
      sel_meta_r <= bus.in_sel;
      sel_sync_r <= sel_meta_r;
    end
  end

  assign smp_s       = smp_sync_r ^ SMP_INV;
  assign sel_s       = sel_sync_r ^ SEL_INV;
  assign sel_valid_s = $onehot(sel_s);
  assign mask_set_s  = mask_r | sel_lat_r;

  // Latched strobe is one-hot, so OR-ing the set positions yields the digit index.
  always_comb begin
    idx_s = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx_s = idx_s | (sel_lat_r[i] ? IDX_W'(i) : IDX_W'(0));
    end
  end

  sevenseg_decode #(
    .INVERSE_NUMBERING (INVERSE_NUMBERING)
  ) u_decode (
    .pattern (smp_lat_r[6:0]),
    .result  (dec_s)
  );

  // Scan-step FSM together with the digit registers and output pulses it writes.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      state_r   <= WAIT_SEL;
      sel_lat_r <= '0;
      smp_lat_r <= '0;
      cnt_r     <= '0;
      mask_r    <= '0;
      digits_r  <= '0;
      valid_r   <= '0;
      update_r  <= 1'b0;
      err_r     <= 1'b0;
      frame_r   <= 1'b0;
`ifdef SEVENSEG_CAPTURE_DP_EN
      dps_r     <= '0;
`endif
    end else begin
      update_r <= 1'b0;
      err_r    <= 1'b0;
      frame_r  <= 1'b0;
      case (state_r)
        WAIT_SEL: begin
          if (sel_valid_s) begin
            state_r   <= SETTLE;
            sel_lat_r <= sel_s;
            smp_lat_r <= smp_s;
            cnt_r     <= '0;
          end
        end
        SETTLE: begin
          if (!sel_valid_s) begin
            state_r <= WAIT_SEL;
          end else if (sel_s != sel_lat_r) begin
            sel_lat_r <= sel_s;
            smp_lat_r <= smp_s;
            cnt_r     <= '0;
          end else if (smp_s != smp_lat_r) begin
            smp_lat_r <= smp_s;
            cnt_r     <= '0;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= CAPTURE;
          end else begin
            cnt_r <= cnt_r + 1'b1;
          end
        end
        CAPTURE: begin
          state_r  <= HOLD;
          update_r <= 1'b1;
          valid_r[idx_s] <= dec_s.hit;
          if (dec_s.hit) begin
            digits_r[{idx_s, 2'b00} +: 4] <= dec_s.nibble;
          end else begin
            err_r <= !dec_s.blank;
          end
`ifdef SEVENSEG_CAPTURE_DP_EN
          dps_r[idx_s] <= smp_lat_r[7];
`endif
          if (&mask_set_s) begin
            frame_r <= 1'b1;
            mask_r  <= '0;
          end else begin
            mask_r  <= mask_set_s;
          end
        end
        HOLD: begin
          if (!sel_valid_s) begin
            state_r <= WAIT_SEL;
          end else if (sel_s != sel_lat_r) begin
            state_r   <= SETTLE;
            sel_lat_r <= sel_s;
            smp_lat_r <= smp_s;
            cnt_r     <= '0;
          end
        end
        default: state_r <= WAIT_SEL;
      endcase
    end
  end

  assign bus.out_digits = digits_r;
  assign bus.out_valid  = valid_r;
  assign bus.out_update = update_r;
  assign bus.out_err    = err_r;
  assign bus.out_frame  = frame_r;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Directed bench for sevenseg_capture: default, inverted/mirrored and single-sample instances.
module tb_sevenseg_capture;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] segs_a;
  logic [3:0] sel_a;
  logic [6:0] segs_b;
  logic [3:0] sel_b;
  logic       dp_a;
  logic       dp_b;

  int checks = 0;
  int errs   = 0;
  int upd_a  = 0;
  int err_a  = 0;
  int frm_a  = 0;

  always #5 clk = ~clk;

  sevenseg_capture_if #(.NUM_DIGITS(4)) bus_a ();
  sevenseg_capture_if #(.NUM_DIGITS(4)) bus_b ();
  sevenseg_capture_if #(.NUM_DIGITS(4)) bus_c ();

  assign bus_a.in_segs = segs_a;
  assign bus_a.in_sel  = sel_a;
  assign bus_c.in_segs = segs_a;
  assign bus_c.in_sel  = sel_a;
  assign bus_b.in_segs = segs_b;
  assign bus_b.in_sel  = sel_b;
`ifdef SEVENSEG_CAPTURE_DP_EN
  assign bus_a.in_dp   = dp_a;
  assign bus_c.in_dp   = dp_a;
  assign bus_b.in_dp   = dp_b;
`endif

  sevenseg_capture dut_a (.in_clk(clk), .in_rst_n(rst_n), .bus(bus_a));

  sevenseg_capture #(
    .ZERO_IS_ON        (1'b1),
    .SEL_ZERO_IS_ON    (1'b1),
    .INVERSE_NUMBERING (1'b1)
  ) dut_b (.in_clk(clk), .in_rst_n(rst_n), .bus(bus_b));

  sevenseg_capture #(
    .STABLE_CYCLES (1)
  ) dut_c (.in_clk(clk), .in_rst_n(rst_n), .bus(bus_c));

  // Pulse tallies for the default instance.
  always @(negedge clk) begin
    if (bus_a.out_update) upd_a <= upd_a + 1;
    if (bus_a.out_err)    err_a <= err_a + 1;
    if (bus_a.out_frame)  frm_a <= frm_a + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [6:0] pat2 [4];
    int cyc_a, cyc_c, n_a, base_u, base_e, base_f;
    pat2 = '{7'h30, 7'h6d, 7'h77, 7'h1f};

    rst_n  = 1'b0;
    segs_a = 7'h00;
    sel_a  = 4'h0;
    segs_b = 7'h7f;
    sel_b  = 4'hf;
    dp_a   = 1'b0;
    dp_b   = 1'b1;
    step(3);
    check_val("rst_digits", 32'(bus_a.out_digits), 32'h0);
    check_val("rst_valid",  32'(bus_a.out_valid),  32'h0);
    check_val("rst_update", 32'(bus_a.out_update), 32'h0);
    check_val("rst_err",    32'(bus_a.out_err),    32'h0);
    check_val("rst_frame",  32'(bus_a.out_frame),  32'h0);
    check_val("rst_b_valid", 32'(bus_b.out_valid), 32'h0);

    // Digit 0 showing "0"; inverted instance shows "2" on active-low pins.
    rst_n  = 1'b1;
    sel_a  = 4'b0001;
    segs_a = 7'h7e;
    sel_b  = 4'b1110;
    segs_b = ~7'h5b;
    dp_b   = 1'b0;
    cyc_a = 0; cyc_c = 0; n_a = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus_a.out_update) begin
        cyc_a = i;
        n_a++;
      end
      if (bus_c.out_update) cyc_c = i;
    end
    check_val("t1_latency",   32'(cyc_a), 32'd8);
    check_val("t1_upd_count", 32'(n_a),   32'd1);
    check_val("t1_digit0",    32'(bus_a.out_digits[3:0]), 32'h0);
    check_val("t1_valid",     32'(bus_a.out_valid), 32'h1);
    check_val("t1_c_latency", 32'(cyc_c), 32'd5);
    check_val("t1_c_valid",   32'(bus_c.out_valid), 32'h1);
    check_val("t6_b_digit0",  32'(bus_b.out_digits[3:0]), 32'h2);
    check_val("t6_b_valid",   32'(bus_b.out_valid), 32'h1);
`ifdef SEVENSEG_CAPTURE_DP_EN
    check_val("t6_a_dps", 32'(bus_a.out_dps), 32'h0);
    check_val("t6_b_dps", 32'(bus_b.out_dps), 32'h1);
`endif

    // Full scan of "12ab".
    sel_a = 4'h0;
    step(4);
    base_u = upd_a; base_f = frm_a;
    for (int d = 0; d < 4; d++) begin
      sel_a  = 4'(1 << d);
      segs_a = pat2[d];
      step(16);
    end
    check_val("t2_digits", 32'(bus_a.out_digits), 32'hba21);
    check_val("t2_valid",  32'(bus_a.out_valid),  32'hf);
    check_val("t2_frames", 32'(frm_a - base_f),   32'd1);
    check_val("t2_updates", 32'(upd_a - base_u),  32'd4);

    // Glitching segments never settle; then a steady "4".
    sel_a = 4'h0;
    step(4);
    base_u = upd_a;
    sel_a = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      segs_a = k[0] ? 7'h33 : 7'h30;
      step(2);
    end
    check_val("t3_no_update", 32'(upd_a - base_u), 32'd0);
    segs_a = 7'h33;
    step(12);
    check_val("t3_digit1",  32'(bus_a.out_digits[7:4]), 32'h4);
    check_val("t3_valid1",  32'(bus_a.out_valid[1]),    32'h1);
    check_val("t3_updates", 32'(upd_a - base_u),        32'd1);

    // Unknown pattern then blank on digit 2.
    sel_a = 4'h0;
    step(4);
    base_u = upd_a; base_e = err_a;
    sel_a  = 4'b0100;
    segs_a = 7'h01;
    step(12);
    check_val("t4_err_pulse", 32'(err_a - base_e), 32'd1);
    check_val("t4_err_upd",   32'(upd_a - base_u), 32'd1);
    check_val("t4_err_valid", 32'(bus_a.out_valid[2]), 32'h0);
    check_val("t4_err_keep",  32'(bus_a.out_digits[11:8]), 32'ha);
    sel_a = 4'h0;
    step(4);
    base_u = upd_a; base_e = err_a;
    sel_a  = 4'b0100;
    segs_a = 7'h00;
    step(12);
    check_val("t4_blank_err",   32'(err_a - base_e), 32'd0);
    check_val("t4_blank_upd",   32'(upd_a - base_u), 32'd1);
    check_val("t4_blank_valid", 32'(bus_a.out_valid[2]), 32'h0);
    check_val("t4_blank_keep",  32'(bus_a.out_digits[11:8]), 32'ha);

    // Invalid strobes, then reset while settling.
    sel_a = 4'h0;
    step(4);
    base_u = upd_a;
    sel_a  = 4'b0011;
    segs_a = 7'h7e;
    step(20);
    sel_a  = 4'b0000;
    step(20);
    check_val("t5_no_update", 32'(upd_a - base_u), 32'd0);
    sel_a = 4'b1000;
    step(4);
    rst_n = 1'b0;
    step(1);
    check_val("t5_rst_digits", 32'(bus_a.out_digits), 32'h0);
    check_val("t5_rst_valid",  32'(bus_a.out_valid),  32'h0);
    check_val("t5_rst_update", 32'(bus_a.out_update), 32'h0);
    check_val("t5_rst_err",    32'(bus_a.out_err),    32'h0);
    check_val("t5_rst_frame",  32'(bus_a.out_frame),  32'h0);
    step(2);
    rst_n = 1'b1;
    step(10);
    check_val("t5_after_valid",  32'(bus_a.out_valid),  32'h8);
    check_val("t5_after_digits", 32'(bus_a.out_digits), 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
